// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI master: FSM state encoding and the
// chip-select index width helper.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_GAP     = 3'd3,
        ST_RELEASE = 3'd4
    } spi_state_t;

    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/sd_spi_fifo.sv
// Synchronous FIFO with extra-bit pointers; DEPTH must be a power of two >= 2.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module sd_spi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/sd_spi_master.sv
// SPI master for SD cards: TX FIFO of {cs, data}, per-word CPOL/CPHA, CS held across same-target words.
// SD_SPI_RX_FIFO_EN selects an RX FIFO instead of a single RX holding register.
//
// state    | meaning
// IDLE     | nothing queued, CS released
// LOAD     | pop TX head, CS asserted, first MOSI bit presented
// SHIFT    | 2*DATA_W SCLK edges, CLK_DIV cycles apart
// GAP      | CLK_DIV cycles after last edge, then RX write
// RELEASE  | all CS high for CLK_DIV cycles
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CS     = 2,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK50,
    input  logic                        RST,
    input  logic                        W_STB,
    input  logic [DATA_W-1:0]           W_DATA,
    input  logic [cs_width(NUM_CS)-1:0] W_CS,
    input  logic                        R_STB,
    output logic [DATA_W-1:0]           R_DATA,
    input  logic                        CPOL,
    input  logic                        CPHA,
    input  logic                        MISO,
    output logic                        MOSI,
    output logic                        SCLK,
    output logic [NUM_CS-1:0]           CS,
    output logic                        BUSY,
    output logic                        TX_FULL,
    output logic                        RX_VALID,
    output logic                        RX_OVR
);

    localparam int CS_W   = cs_width(NUM_CS);
    localparam int TXW    = CS_W + DATA_W;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * DATA_W);

    spi_state_t        state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [EDGE_W-1:0] edge_cnt_q;
    logic              cpol_q, cpha_q, sclk_q;
    logic [CS_W-1:0]   cs_idx_q;
    logic [NUM_CS-1:0] cs_n_q, cs_dec;
    logic [DATA_W:0]   tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic              rx_ovr_q;

    logic              tx_pop, tx_full, tx_empty;
    logic [TXW-1:0]    tx_head;
    logic [CS_W-1:0]   head_cs;
    logic [DATA_W-1:0] head_data;
    logic              div_tc, samp_edge;
    logic              rx_wr, rx_full;

    sd_spi_fifo #(.WIDTH(TXW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (CLK50),
        .rst     (RST),
        .push    (W_STB),
        .pop     (tx_pop),
        .wr_data ({W_CS, W_DATA}),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign head_cs   = tx_head[TXW-1:DATA_W];
    assign head_data = tx_head[DATA_W-1:0];
    assign div_tc    = (div_cnt_q == '0);
    // Odd remaining-edge counts are leading edges; sample when lead differs from CPHA.
    assign samp_edge = edge_cnt_q[0] ^ cpha_q;

    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (head_cs == CS_W'(i)) cs_dec[i] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_pop  = 1'b0;
        rx_wr   = 1'b0;
        case (state_q)
            ST_IDLE:    if (!tx_empty) state_d = ST_LOAD;
            ST_LOAD: begin
                tx_pop  = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT:   if (div_tc && edge_cnt_q == '0) state_d = ST_GAP;
            ST_GAP: begin
                if (div_tc) begin
                    rx_wr = 1'b1;
                    if (!tx_empty && head_cs == cs_idx_q) state_d = ST_LOAD;
                    else                                  state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: if (div_tc) state_d = tx_empty ? ST_IDLE : ST_LOAD;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK50) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_idx_q   <= '0;
            cs_n_q     <= '1;
            tx_sh_q    <= '1;
            rx_sh_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_LOAD: begin
                    // CLK_DIV-2 so the first edge lands CLK_DIV cycles after LOAD.
                    div_cnt_q  <= DIV_W'(CLK_DIV - 2);
                    edge_cnt_q <= EDGE_W'(2 * DATA_W - 1);
                end
                ST_SHIFT: begin
                    if (div_tc) begin
                        sclk_q     <= ~sclk_q;
                        div_cnt_q  <= DIV_W'(CLK_DIV - 1);
                        edge_cnt_q <= edge_cnt_q - EDGE_W'(1);
                        if (samp_edge) rx_sh_q <= {rx_sh_q[DATA_W-2:0], MISO};
                        else           tx_sh_q <= {tx_sh_q[DATA_W-1:0], 1'b1};
                    end else begin
                        div_cnt_q <= div_cnt_q - DIV_W'(1);
                    end
                end
                ST_GAP, ST_RELEASE: begin
                    if (div_tc) div_cnt_q <= DIV_W'(CLK_DIV - 1);
                    else        div_cnt_q <= div_cnt_q - DIV_W'(1);
                end
                default: ;
            endcase
            if (state_d == ST_LOAD) begin
                cpol_q   <= CPOL;
                cpha_q   <= CPHA;
                sclk_q   <= CPOL;
                cs_idx_q <= head_cs;
                cs_n_q   <= cs_dec;
                // CPHA=1 parks a dummy 1 so the first leading edge shifts in the MSB.
                tx_sh_q  <= CPHA ? {1'b1, head_data} : {head_data, 1'b1};
            end else if (state_d == ST_IDLE || state_d == ST_RELEASE) begin
                cs_n_q <= '1;
            end
        end
    end

`ifdef SD_SPI_RX_FIFO_EN
    logic              rx_empty;
    logic [DATA_W-1:0] rx_head;

    sd_spi_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (CLK50),
        .rst     (RST),
        .push    (rx_wr),
        .pop     (R_STB),
        .wr_data (rx_sh_q),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign RX_VALID = !rx_empty;
    assign R_DATA   = rx_empty ? '0 : rx_head;
`else
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;

    assign rx_full = rx_valid_q;

    always_ff @(posedge CLK50) begin
        if (RST) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else if (rx_wr && (!rx_valid_q || R_STB)) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_sh_q;
        end else if (R_STB) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign RX_VALID = rx_valid_q;
    assign R_DATA   = rx_data_q;
`endif

    // A read in the same cycle frees a slot, so only an unread full RX overruns.
    always_ff @(posedge CLK50) begin
        if (RST)                              rx_ovr_q <= 1'b0;
        else if (rx_wr && rx_full && !R_STB)  rx_ovr_q <= 1'b1;
    end

    assign RX_OVR  = rx_ovr_q;
    assign CS      = cs_n_q;
    assign SCLK    = sclk_q;
    assign MOSI    = tx_sh_q[DATA_W];
    assign BUSY    = (state_q != ST_IDLE);
    assign TX_FULL = tx_full;

endmodule

// File: tb/tb_sd_spi_master.sv
// Self-checking bench for sd_spi_master: scoreboard of expected RX words plus CS/SCLK framing checks.
module tb_sd_spi_master;

    localparam int DATA_W     = 8;
    localparam int NUM_CS     = 2;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef SD_SPI_RX_FIFO_EN
    localparam logic EXP_OVR = 1'b0;
`else
    localparam logic EXP_OVR = 1'b1;
`endif

    logic              clk;
    logic              rst;
    logic              w_stb;
    logic [DATA_W-1:0] w_data;
    logic [0:0]        w_cs;
    logic              r_stb;
    logic [DATA_W-1:0] r_data;
    logic              cpol, cpha;
    logic              miso, mosi, sclk;
    logic [NUM_CS-1:0] cs;
    logic              busy, tx_full, rx_valid, rx_ovr;
    logic              loop_en, miso_fix;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    sd_spi_master #(
        .DATA_W(DATA_W), .NUM_CS(NUM_CS), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK50(clk), .RST(rst), .W_STB(w_stb), .W_DATA(w_data), .W_CS(w_cs),
        .R_STB(r_stb), .R_DATA(r_data), .CPOL(cpol), .CPHA(cpha), .MISO(miso),
        .MOSI(mosi), .SCLK(sclk), .CS(cs), .BUSY(busy), .TX_FULL(tx_full),
        .RX_VALID(rx_valid), .RX_OVR(rx_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : miso_fix;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic cs_i, input logic [DATA_W-1:0] d);
        w_cs   = cs_i;
        w_data = d;
        w_stb  = 1'b1;
        tick();
        w_stb  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cs !== 2'b11)  begin errors++; $display("FAIL reset_cs got %b want 11", cs); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi got %b want 1", mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL reset_rx_ovr got %b want 0", rx_ovr); end
        checks++; if (r_data !== '0)  begin errors++; $display("FAIL reset_r_data got %h want 00", r_data); end
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full got %b want 0", tx_full); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mode0_loop();
        logic prev_cs0, prev_sclk, both_low, done;
        int   windows, pulses;
        logic [DATA_W-1:0] exp;
        cpol = 1'b0; cpha = 1'b0; loop_en = 1'b1;
        prev_cs0 = cs[0]; prev_sclk = sclk; both_low = 1'b0; done = 1'b0;
        windows = 0; pulses = 0;
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hB3);
        write_word(1'b0, 8'hAB);
        write_word(1'b0, 8'hB3);
        for (int i = 0; i < 600 && !done; i++) begin
            tick();
            r_stb = 1'b0;
            if (cs == 2'b00) both_low = 1'b1;
            if (prev_cs0 && !cs[0]) windows++;
            if (!prev_sclk && sclk && !cs[0]) pulses++;
            prev_cs0 = cs[0]; prev_sclk = sclk;
            if (rx_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL mode0_rx got unexpected %h want none", r_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (r_data !== exp) begin errors++; $display("FAIL mode0_rx got %h want %h", r_data, exp); end
                end
                r_stb = 1'b1;
            end
            if (exp_q.size() == 0 && !busy && !rx_valid) done = 1'b1;
        end
        r_stb = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL mode0_timeout got pending %0d want 0", exp_q.size()); end
        checks++; if (windows != 1) begin errors++; $display("FAIL mode0_cs_windows got %0d want 1", windows); end
        checks++; if (pulses != 16) begin errors++; $display("FAIL mode0_sclk_pulses got %0d want 16", pulses); end
        checks++; if (both_low)     begin errors++; $display("FAIL mode0_cs_onehot got both low want at most one"); end
        exp_q.delete();
    endtask

    task automatic test_mode3();
        logic prev_sclk, done;
        int   falls;
        logic [DATA_W-1:0] exp;
        cpol = 1'b1; cpha = 1'b1; loop_en = 1'b0; miso_fix = 1'b1;
        prev_sclk = sclk; falls = 0; done = 1'b0;
        exp_q.push_back(8'hFF);
        write_word(1'b0, 8'h55);
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            r_stb = 1'b0;
            if (prev_sclk && !sclk && !cs[0]) falls++;
            prev_sclk = sclk;
            if (rx_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL mode3_rx got unexpected %h want none", r_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (r_data !== exp) begin errors++; $display("FAIL mode3_rx got %h want %h", r_data, exp); end
                end
                r_stb = 1'b1;
            end
            if (exp_q.size() == 0 && !busy && !rx_valid) done = 1'b1;
        end
        r_stb = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL mode3_timeout got pending %0d want 0", exp_q.size()); end
        checks++; if (falls != 8)    begin errors++; $display("FAIL mode3_leading_edges got %0d want 8", falls); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL mode3_sclk_idle got %b want 1", sclk); end
        checks++; if (cs !== 2'b11)  begin errors++; $display("FAIL mode3_cs_idle got %b want 11", cs); end
        exp_q.delete();
    endtask

    task automatic test_cs_switch();
        logic prev_cs0, prev_cs1, seen_rise, seen_fall1, both_low, done;
        int   high_cnt;
        logic [DATA_W-1:0] exp;
        cpol = 1'b0; cpha = 1'b0; loop_en = 1'b1;
        prev_cs0 = cs[0]; prev_cs1 = cs[1];
        seen_rise = 1'b0; seen_fall1 = 1'b0; both_low = 1'b0; done = 1'b0; high_cnt = 0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        write_word(1'b0, 8'h11);
        write_word(1'b1, 8'h22);
        for (int i = 0; i < 600 && !done; i++) begin
            tick();
            r_stb = 1'b0;
            if (cs == 2'b00) both_low = 1'b1;
            if (!prev_cs0 && cs[0]) seen_rise = 1'b1;
            if (seen_rise && !seen_fall1 && cs == 2'b11) high_cnt++;
            if (seen_rise && prev_cs1 && !cs[1]) seen_fall1 = 1'b1;
            prev_cs0 = cs[0]; prev_cs1 = cs[1];
            if (rx_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL switch_rx got unexpected %h want none", r_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (r_data !== exp) begin errors++; $display("FAIL switch_rx got %h want %h", r_data, exp); end
                end
                r_stb = 1'b1;
            end
            if (exp_q.size() == 0 && !busy && !rx_valid) done = 1'b1;
        end
        r_stb = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL switch_timeout got pending %0d want 0", exp_q.size()); end
        checks++; if (!seen_fall1) begin errors++; $display("FAIL switch_cs1_fall got none want one"); end
        checks++; if (high_cnt != CLK_DIV) begin errors++; $display("FAIL switch_release_len got %0d want %0d", high_cnt, CLK_DIV); end
        checks++; if (both_low) begin errors++; $display("FAIL switch_cs_onehot got both low want at most one"); end
        exp_q.delete();
    endtask

    task automatic test_tx_full();
        logic done;
        int   rcv;
        logic [DATA_W-1:0] exp;
        cpol = 1'b0; cpha = 1'b0; loop_en = 1'b1; done = 1'b0; rcv = 0;
        exp_q.push_back(8'h3C);
        write_word(1'b0, 8'h3C);
        tick();
        tick();
        // Primer word is now shifting, so the next writes pile up in the TX FIFO.
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) exp_q.push_back(8'hC0 + k[7:0]);
            write_word(1'b0, 8'hC0 + k[7:0]);
            if (k == 3) begin
                checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL full_after3 got %b want 0", tx_full); end
            end
            if (k == 4) begin
                checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL full_after4 got %b want 1", tx_full); end
            end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b want 1", busy); end
        for (int i = 0; i < 1500 && !done; i++) begin
            tick();
            r_stb = 1'b0;
            if (rx_valid) begin
                checks++;
                rcv++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL full_rx got unexpected %h want none", r_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (r_data !== exp) begin errors++; $display("FAIL full_rx got %h want %h", r_data, exp); end
                end
                r_stb = 1'b1;
            end
            if (exp_q.size() == 0 && !busy && !rx_valid) done = 1'b1;
        end
        r_stb = 1'b0;
        checks++; if (!done)   begin errors++; $display("FAIL full_timeout got pending %0d want 0", exp_q.size()); end
        checks++; if (rcv != 5) begin errors++; $display("FAIL full_word_count got %0d want 5", rcv); end
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL full_drained got %b want 0", tx_full); end
        exp_q.delete();
    endtask

    task automatic test_overrun();
        logic seen_busy, done;
        cpol = 1'b0; cpha = 1'b0; loop_en = 1'b1; seen_busy = 1'b0; done = 1'b0;
        write_word(1'b0, 8'h5A);
        write_word(1'b0, 8'hA5);
        for (int i = 0; i < 600 && !done; i++) begin
            tick();
            if (busy) seen_busy = 1'b1;
            if (seen_busy && !busy) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL ovr_timeout got busy %b want 0", busy); end
        checks++; if (rx_ovr !== EXP_OVR) begin errors++; $display("FAIL ovr_flag got %b want %b", rx_ovr, EXP_OVR); end
        checks++; if (r_data !== 8'h5A) begin errors++; $display("FAIL ovr_r_data got %h want 5a", r_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_rx_valid got %b want 1", rx_valid); end
    endtask

    task automatic test_reset_mid();
        logic woke;
        cpol = 1'b0; cpha = 1'b0; loop_en = 1'b1; woke = 1'b0;
        write_word(1'b0, 8'h77);
        write_word(1'b0, 8'h78);
        write_word(1'b1, 8'h79);
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (cs !== 2'b11)   begin errors++; $display("FAIL mid_cs got %b want 11", cs); end
        checks++; if (sclk !== 1'b0)  begin errors++; $display("FAIL mid_sclk got %b want 0", sclk); end
        checks++; if (mosi !== 1'b1)  begin errors++; $display("FAIL mid_mosi got %b want 1", mosi); end
        checks++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL mid_rx_ovr got %b want 0", rx_ovr); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rx_valid got %b want 0", rx_valid); end
        checks++; if (r_data !== '0)  begin errors++; $display("FAIL mid_r_data got %h want 00", r_data); end
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (busy || rx_valid || cs != 2'b11) woke = 1'b1;
        end
        checks++; if (woke) begin errors++; $display("FAIL mid_fifo_discard got activity want idle"); end
    endtask

    initial begin
        rst = 1'b1; w_stb = 1'b0; w_data = '0; w_cs = '0; r_stb = 1'b0;
        cpol = 1'b0; cpha = 1'b0; loop_en = 1'b0; miso_fix = 1'b0;
        test_reset();
        test_mode0_loop();
        test_mode3();
        test_cs_switch();
        test_tx_full();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
